thermal_plant_model: RTL and testbench
======================================

Name: thermal_plant_model

Overview:
- Closed-loop stimulus block: a behavioural room/plant model.
- Consumes the heating/cooling demands produced by the heating controller and generates the 5-bit temperature that controller reads.
- Replaces the open-loop ramp stimulus, so the controller can be checked against a plant that responds to its outputs.
- Synthesisable, so it can also drive the controller's temperature pins on the board.

Parameters:
- INIT_TEMP, 18: temperature loaded on reset (0..31).
- AMBIENT, 18: drift target when idle (0..31).
- HEAT_DIV, 4: clock cycles per +1 step while heating (>=1).
- COOL_DIV, 4: clock cycles per -1 step while cooling (>=1).
- DRIFT_DIV, 16: clock cycles per 1-step move toward AMBIENT while idle (>=1).
- CNT_W, 8: divider counter width; must satisfy 2^CNT_W > max divider.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- heating  input  1  heater demand from controller.
- cooling  input  1  cooler demand from controller.
- temperature  output  5  current plant temperature, registered.
- mode  output  2  registered mode: 00 IDLE, 01 HEAT, 10 COOL, 11 FAULT.
- step  output  1  one-cycle pulse, high in the cycle after temperature changed.
- fault  output  1  high while mode is FAULT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high; all state changes occur on the rising edge of clk.
- Reset values: temperature=INIT_TEMP, mode=IDLE, counter=0, step=0, fault=0.
  - Reset mid-operation overrides everything on that edge, including a pending step.
- Next mode each edge, decoded from sampled inputs:
  - heating=1, cooling=0 -> HEAT
  - heating=0, cooling=1 -> COOL
  - both 0 -> IDLE
  - both 1 -> FAULT
- Mode change: on any edge where next mode differs from the registered mode:
  - mode updates;
  - counter clears to 0;
  - no temperature step on that edge.
- Same mode: the counter increments each edge. When counter==DIV-1 for the active mode:
  - counter returns to 0;
  - a step is applied.
  - Result: first step lands on the (DIV+1)th edge with the demand held; subsequent steps every DIV edges.
- HEAT step: temperature+1, saturating at 31. At 31 no change and no step pulse; the counter still wraps.
- COOL step: temperature-1, saturating at 0. Same no-pulse rule at 0.
- IDLE step (DRIFT_DIV):
  - temperature < AMBIENT -> +1;
  - temperature > AMBIENT -> -1;
  - equal -> no change, no pulse.
- FAULT:
  - temperature frozen; counter held at 0; fault=1.
  - Leaving FAULT follows the normal mode-change rule.
- step: registered; 1 for exactly one cycle after each edge where temperature changed value.
- Arithmetic: 5-bit unsigned; never wraps 31->0 or 0->31.
- A divider parameter of 1 gives a step every edge after the mode-change edge.

Optional Feature:
- Macro: SENSOR_NOISE_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5 on reset, advances every edge.
  - Reported temperature = internal temperature + noise, where noise = +1 if LFSR[1:0]==2'b01, -1 if 2'b10, else 0; saturated to 0..31.
  - Internal plant value and the step pulse are unaffected by noise.
  - The output is registered, with the same timing as the noiseless path.
- Undefined: temperature equals the internal plant value exactly; no LFSR logic present.

Test Plan:
- Reset: rst=1 for 3 edges with heating=1 -> temperature=18, mode=00, step=0, fault=0 throughout.
- Heat ramp: after reset, heating=1 held 21 edges (HEAT_DIV=4) -> temperature 18,...,23. First change on the 5th edge, then every 4 edges; one step pulse per change.
- Saturation: INIT_TEMP=30, HEAT_DIV=1, heating=1 for 10 edges -> temperature 31, then holds 31 with no further step pulses.
- Cool floor: INIT_TEMP=1, COOL_DIV=2, cooling=1 -> 1 to 0 on edge 3, then holds 0; no wrap to 31.
- Drift and fault:
  - INIT_TEMP=22, idle -> decrements every 16 edges to 18, then stops.
  - Assert heating=cooling=1 mid-drift -> mode=11, fault=1, temperature frozen.
  - Release to idle -> counter restarts and the next drift step lands 17 edges later.
- Reset mid-ramp: assert rst on the edge a HEAT step is due -> temperature=INIT_TEMP, no step pulse, counter=0.
- Noise (SENSOR_NOISE_EN defined): 256 edges idle at AMBIENT -> output stays within AMBIENT±1 and step stays 0.

Source files
------------

// File: rtl/thermal_plant_model.sv
// Behavioural room/plant model: integrates heating/cooling demand into a 5-bit temperature.
// Optional `SENSOR_NOISE_EN adds LFSR-based +/-1 noise to the reported temperature only.
module thermal_plant_model #(
    parameter int INIT_TEMP = 18,
    parameter int AMBIENT   = 18,
    parameter int HEAT_DIV  = 4,
    parameter int COOL_DIV  = 4,
    parameter int DRIFT_DIV = 16,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    output logic [4:0] temperature,
    output logic [1:0] mode,
    output logic       step,
    output logic       fault
);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_HEAT  = 2'b01,
        MODE_COOL  = 2'b10,
        MODE_FAULT = 2'b11
    } mode_t;

    localparam logic [4:0]       INIT_T    = 5'(INIT_TEMP);
    localparam logic [4:0]       AMB_T     = 5'(AMBIENT);
    localparam logic [CNT_W-1:0] HEAT_LIM  = CNT_W'(HEAT_DIV - 1);
    localparam logic [CNT_W-1:0] COOL_LIM  = CNT_W'(COOL_DIV - 1);
    localparam logic [CNT_W-1:0] DRIFT_LIM = CNT_W'(DRIFT_DIV - 1);

    mode_t            mode_q, mode_d, req_mode;
    logic [4:0]       temp_q, temp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, lim;
    logic             step_q, step_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_IDLE;
            temp_q <= INIT_T;
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            temp_q <= temp_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        temp_d = temp_q;
        cnt_d  = cnt_q;
        step_d = 1'b0;

        case ({heating, cooling})
            2'b10:   req_mode = MODE_HEAT;
            2'b01:   req_mode = MODE_COOL;
            2'b11:   req_mode = MODE_FAULT;
            default: req_mode = MODE_IDLE;
        endcase

        case (mode_q)
            MODE_HEAT: lim = HEAT_LIM;
            MODE_COOL: lim = COOL_LIM;
            MODE_IDLE: lim = DRIFT_LIM;
            default:   lim = '0;
        endcase

        // A mode change only restarts the divider; the step waits a full period.
        if (req_mode != mode_q) begin
            mode_d = req_mode;
            cnt_d  = '0;
        end else if (mode_q == MODE_FAULT) begin
            cnt_d = '0;
        end else if (cnt_q == lim) begin
            cnt_d = '0;
            case (mode_q)
                MODE_HEAT: if (temp_q != 5'd31) temp_d = temp_q + 5'd1;
                MODE_COOL: if (temp_q != 5'd0)  temp_d = temp_q - 5'd1;
                MODE_IDLE: begin
                    if (temp_q < AMB_T)      temp_d = temp_q + 5'd1;
                    else if (temp_q > AMB_T) temp_d = temp_q - 5'd1;
                end
                default: temp_d = temp_q;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        step_d = (temp_d != temp_q);
    end

    assign mode  = mode_q;
    assign step  = step_q;
    assign fault = (mode_q == MODE_FAULT);

`ifdef SENSOR_NOISE_EN
    logic [7:0] lfsr_q;
    logic [4:0] temp_out_q, noisy_d;

    // Noise is applied to the next plant value so the reported path keeps plant timing.
    always_comb begin
        noisy_d = temp_d;
        if (lfsr_q[1:0] == 2'b01 && temp_d != 5'd31)     noisy_d = temp_d + 5'd1;
        else if (lfsr_q[1:0] == 2'b10 && temp_d != 5'd0) noisy_d = temp_d - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= 8'hA5;
            temp_out_q <= INIT_T;
        end else begin
            lfsr_q     <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            temp_out_q <= noisy_d;
        end
    end

    assign temperature = temp_out_q;
`else
    assign temperature = temp_q;
`endif

endmodule

// File: tb/tb_thermal_plant_model.sv
// Directed bench for thermal_plant_model: four instances with different parameter sets,
// all sharing clock and reset; each scenario task checks its own expected values inline.
module tb_thermal_plant_model;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a: defaults, s: saturation, c: cool floor, d: drift/fault
    logic       heat_a = 0, cool_a = 0, heat_s = 0, cool_s = 0;
    logic       heat_c = 0, cool_c = 0, heat_d = 0, cool_d = 0;
    logic [4:0] t_a, t_s, t_c, t_d;
    logic [1:0] m_a, m_s, m_c, m_d;
    logic       s_a, s_s, s_c, s_d;
    logic       f_a, f_s, f_c, f_d;

    int total = 0;
    int bad   = 0;

    thermal_plant_model dut_a (
        .clk(clk), .rst(rst), .heating(heat_a), .cooling(cool_a),
        .temperature(t_a), .mode(m_a), .step(s_a), .fault(f_a)
    );
    thermal_plant_model #(.INIT_TEMP(30), .HEAT_DIV(1)) dut_s (
        .clk(clk), .rst(rst), .heating(heat_s), .cooling(cool_s),
        .temperature(t_s), .mode(m_s), .step(s_s), .fault(f_s)
    );
    thermal_plant_model #(.INIT_TEMP(1), .COOL_DIV(2)) dut_c (
        .clk(clk), .rst(rst), .heating(heat_c), .cooling(cool_c),
        .temperature(t_c), .mode(m_c), .step(s_c), .fault(f_c)
    );
    thermal_plant_model #(.INIT_TEMP(22)) dut_d (
        .clk(clk), .rst(rst), .heating(heat_d), .cooling(cool_d),
        .temperature(t_d), .mode(m_d), .step(s_d), .fault(f_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        heat_a = 0; cool_a = 0; heat_s = 0; cool_s = 0;
        heat_c = 0; cool_c = 0; heat_d = 0; cool_d = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        heat_a = 1'b1;
        rst    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (t_a !== 5'd18 || m_a !== 2'b00 || s_a !== 1'b0 || f_a !== 1'b0) begin
                bad++;
                $display("FAIL reset edge %0d: temp=%0d mode=%b step=%b fault=%b, want 18/00/0/0",
                         k, t_a, m_a, s_a, f_a);
            end
        end
        rst    = 1'b0;
        heat_a = 1'b0;
    endtask

    // Heat ramp followed by a reset landing exactly on a due step.
    task automatic test_heat_ramp();
        logic [4:0] exp_t;
        logic       exp_s;
        do_reset();
        heat_a = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            exp_t = 5'(18 + ((k >= 5) ? (k - 1) / 4 : 0));
            exp_s = (k >= 5) && ((k - 1) % 4 == 0);
            total++;
            if (t_a !== exp_t || s_a !== exp_s || m_a !== 2'b01) begin
                bad++;
                $display("FAIL heat_ramp edge %0d: temp=%0d step=%b mode=%b, want %0d/%b/01",
                         k, t_a, s_a, m_a, exp_t, exp_s);
            end
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        total++;
        if (t_a !== 5'd18 || s_a !== 1'b0 || m_a !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_ramp: temp=%0d step=%b mode=%b, want 18/0/00", t_a, s_a, m_a);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_t = (k == 5) ? 5'd19 : 5'd18;
            exp_s = (k == 5);
            total++;
            if (t_a !== exp_t || s_a !== exp_s) begin
                bad++;
                $display("FAIL restart_after_reset edge %0d: temp=%0d step=%b, want %0d/%b",
                         k, t_a, s_a, exp_t, exp_s);
            end
        end
        heat_a = 1'b0;
    endtask

    task automatic test_saturation();
        logic [4:0] exp_t;
        do_reset();
        heat_s = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_t = (k >= 2) ? 5'd31 : 5'd30;
            total++;
            if (t_s !== exp_t || s_s !== (k == 2)) begin
                bad++;
                $display("FAIL saturation edge %0d: temp=%0d step=%b, want %0d/%b",
                         k, t_s, s_s, exp_t, (k == 2));
            end
        end
        heat_s = 1'b0;
    endtask

    task automatic test_cool_floor();
        logic [4:0] exp_t;
        do_reset();
        cool_c = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_t = (k >= 3) ? 5'd0 : 5'd1;
            total++;
            if (t_c !== exp_t || s_c !== (k == 3) || m_c !== 2'b10) begin
                bad++;
                $display("FAIL cool_floor edge %0d: temp=%0d step=%b mode=%b, want %0d/%b/10",
                         k, t_c, s_c, m_c, exp_t, (k == 3));
            end
        end
        cool_c = 1'b0;
    endtask

    task automatic test_drift_fault();
        logic [4:0] exp_t;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_t = 5'(22 - k / 16);
            total++;
            if (t_d !== exp_t || s_d !== (k % 16 == 0)) begin
                bad++;
                $display("FAIL drift edge %0d: temp=%0d step=%b, want %0d/%b",
                         k, t_d, s_d, exp_t, (k % 16 == 0));
            end
        end
        heat_d = 1'b1;
        cool_d = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (t_d !== 5'd20 || m_d !== 2'b11 || f_d !== 1'b1 || s_d !== 1'b0) begin
                bad++;
                $display("FAIL fault edge %0d: temp=%0d mode=%b fault=%b step=%b, want 20/11/1/0",
                         k, t_d, m_d, f_d, s_d);
            end
        end
        heat_d = 1'b0;
        cool_d = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            tick();
            exp_t = (k >= 33) ? 5'd18 : ((k >= 17) ? 5'd19 : 5'd20);
            total++;
            if (t_d !== exp_t || s_d !== (k == 17 || k == 33) || f_d !== 1'b0) begin
                bad++;
                $display("FAIL drift_after_fault edge %0d: temp=%0d step=%b fault=%b, want %0d/%b/0",
                         k, t_d, s_d, f_d, exp_t, (k == 17 || k == 33));
            end
        end
    endtask

`ifdef SENSOR_NOISE_EN
    task automatic test_noise();
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            tick();
            total++;
            if (t_a < 5'd17 || t_a > 5'd19 || s_a !== 1'b0) begin
                bad++;
                $display("FAIL noise edge %0d: temp=%0d step=%b, want 17..19/0", k, t_a, s_a);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SENSOR_NOISE_EN
        test_noise();
`else
        test_heat_ramp();
        test_saturation();
        test_cool_floor();
        test_drift_fault();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
